// File: rtl/dbg_trace_drain.sv
// Retire-record trace drain: buffers one debug record per retired instruction
// and serializes each one into a tagged stream of 32-bit words over valid/ready.
module dbg_trace_drain #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_en,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [6:0]                 in_op,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_result,
    input  logic                       in_regwrite,
    input  logic                       in_memtoreg,
    input  logic                       in_dmem_we,
    input  logic [31:0]                in_dmem_addr,
    input  logic [31:0]                in_dmem_wd,
    input  logic [31:0]                in_dmem_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_word,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] SYNC = 7'h52;

    typedef struct packed {
        logic [31:0] hdr;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] addr;
        logic [31:0] data;
        logic        long_rec;
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    rec_t          mem [DEPTH];
    rec_t          in_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] remaining;
    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          push_req, push_ok, fire, last_word, pop;

    // The W4 payload is resolved at capture time so only one data word is stored.
    assign in_rec.hdr      = {SYNC, in_op, in_rs1, in_rs2, in_rd,
                              in_regwrite, in_memtoreg, in_dmem_we};
    assign in_rec.pc       = in_pc;
    assign in_rec.result   = in_result;
    assign in_rec.addr     = in_dmem_addr;
    assign in_rec.data     = in_dmem_we ? in_dmem_wd : in_dmem_rd;
    assign in_rec.long_rec = in_dmem_we | in_memtoreg;

    // Space is judged on the registered count, so a same-cycle pop never frees room.
    assign push_req  = in_valid && trace_en;
    assign push_ok   = push_req && (count < CW'(DEPTH));
    assign head      = mem[rd_ptr];
    assign last_word = head.long_rec ? (idx == 3'd4) : (idx == 3'd2);
    assign fire      = out_valid && out_ready;
    assign pop       = fire && last_word;
    assign remaining = count - CW'(1) + CW'(push_ok);

    assign fifo_count = count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        out_valid = 1'b0;
        out_word  = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 || push_ok) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = last_word;
                case (idx)
                    3'd0:    out_word = head.hdr;
                    3'd1:    out_word = head.pc;
                    3'd2:    out_word = head.result;
                    3'd3:    out_word = head.addr;
                    default: out_word = head.data;
                endcase
                if (fire) begin
                    if (last_word) begin
                        idx_nxt = '0;
                        if (remaining == '0)
                            state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            count  <= count + CW'(push_ok) - CW'(pop);
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    // NOTE: record storage is not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= in_rec;
    end

endmodule
